// File: rtl/alu_seq_shifter_if.sv
// Request/response handshake bundle for the multi-cycle shifter.
// master = requester/consumer side, slave = shifter side.
interface alu_seq_shifter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int AMT_WIDTH  = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] a_in;
  logic [AMT_WIDTH-1:0]  amt_in;
  logic [1:0]            op_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] shift_out;
  logic                  shift_flag;

  modport master (
    output in_valid, a_in, amt_in, op_in, out_ready,
    input  in_ready, out_valid, shift_out, shift_flag
  );

  modport slave (
    input  in_valid, a_in, amt_in, op_in, out_ready,
    output in_ready, out_valid, shift_out, shift_flag
  );
endinterface

// File: rtl/alu_seq_shifter.sv
// Multi-cycle shifter/rotator: one bit position per clock, valid/ready on both sides.
// Build option ALU_ARITH_SHIFT_EN turns op 10 from ror into an arithmetic right shift.
module alu_seq_shifter #(
  parameter int DATA_WIDTH = 16,
  parameter int AMT_WIDTH  = 4
) (
  input  logic               clk,
  input  logic               rst_shift,
  alu_seq_shifter_if.slave   bus
);
  localparam int W = DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               state;
  logic [W-1:0]         shift_q;
  logic                 flag_q;
  logic [AMT_WIDTH-1:0] count;
  logic [1:0]           op_q;
  logic [W-1:0]         step_out;
  logic                 step_flag;

  // One 1-bit step of the latched op applied to the current result.
  always_comb begin
    step_out  = shift_q;
    step_flag = flag_q;
    case (op_q)
      2'b00: begin
        step_out  = {1'b0, shift_q[W-1:1]};
        step_flag = shift_q[0];
      end
      2'b01: begin
        step_out  = {shift_q[W-2:0], 1'b0};
        step_flag = shift_q[W-1];
      end
      2'b10: begin
`ifdef ALU_ARITH_SHIFT_EN
        step_out  = {shift_q[W-1], shift_q[W-1:1]};
`else
        step_out  = {shift_q[0], shift_q[W-1:1]};
`endif
        step_flag = shift_q[0];
      end
      default: begin
        step_out  = {shift_q[W-2:0], shift_q[W-1]};
        step_flag = shift_q[W-1];
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_shift) begin
    if (!rst_shift) begin
      state   <= IDLE;
      shift_q <= '0;
      flag_q  <= 1'b0;
      count   <= '0;
      op_q    <= 2'b00;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          shift_q <= bus.a_in;
          count   <= bus.amt_in;
          op_q    <= bus.op_in;
          flag_q  <= 1'b0;
          state   <= SHIFT;
        end
        SHIFT: if (count == '0) begin
          state <= DONE;
        end else begin
          shift_q <= step_out;
          flag_q  <= step_flag;
          count   <= count - AMT_WIDTH'(1);
        end
        DONE: if (bus.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake flags decode straight from the state register; no input bypass.
  assign bus.in_ready   = (state == IDLE);
  assign bus.out_valid  = (state == DONE);
  assign bus.shift_out  = shift_q;
  assign bus.shift_flag = flag_q;
endmodule

// File: tb/tb_alu_seq_shifter.sv
// Self-checking bench for alu_seq_shifter: vector table, scoreboard queue, handshake corner cases.
module tb_alu_seq_shifter;
  localparam int W = 16;
  localparam int A = 4;

  logic clk = 1'b0;
  logic rst_shift = 1'b0;
  always #5 clk = ~clk;

  alu_seq_shifter_if #(.DATA_WIDTH(W), .AMT_WIDTH(A)) bus ();

  alu_seq_shifter #(.DATA_WIDTH(W), .AMT_WIDTH(A)) dut (
    .clk       (clk),
    .rst_shift (rst_shift),
    .bus       (bus)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [A-1:0] amt;
    logic [1:0]   op;
    logic [W-1:0] exp;
    logic         exp_flag;
  } vec_t;

  typedef struct {
    logic [W-1:0] exp;
    logic         flag;
    int           lat;
  } sb_t;

  sb_t sb[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference built from whole-word shifts, independent of the stepwise datapath.
  function automatic logic [W:0] model(input logic [W-1:0] a, input int n, input logic [1:0] op);
    logic [W-1:0] r;
    logic f;
    if (n == 0) begin
      r = a; f = 1'b0;
    end else begin
      case (op)
        2'b00: begin r = a >> n; f = a[n-1]; end
        2'b01: begin r = a << n; f = a[W-n]; end
`ifdef ALU_ARITH_SHIFT_EN
        2'b10: begin r = W'($signed(a) >>> n); f = a[n-1]; end
`else
        2'b10: begin r = (a >> n) | (a << (W-n)); f = a[n-1]; end
`endif
        default: begin r = (a << n) | (a >> (W-n)); f = a[W-n]; end
      endcase
    end
    return {f, r};
  endfunction

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
    chk("in_ready_before_req", 32'(bus.in_ready), 32'd1);
  endtask

  // Issue one request, push its expectation, then pop and compare when out_valid rises.
  task automatic run_job(input vec_t v, input int hold);
    sb_t e;
    int lat;
    wait_idle();
    bus.in_valid = 1'b1; bus.a_in = v.a; bus.amt_in = v.amt; bus.op_in = v.op;
    bus.out_ready = (hold == 0);
    @(posedge clk);
    e.exp = v.exp; e.flag = v.exp_flag; e.lat = int'(v.amt) + 1;
    sb.push_back(e);
    #1;
    bus.in_valid = 1'b0; bus.a_in = W'($urandom); bus.amt_in = A'($urandom); bus.op_in = 2'($urandom);
    lat = 0;
    do begin @(posedge clk); lat++; #1; end while (!bus.out_valid && lat < 40);
    e = sb.pop_front();
    if (!bus.out_valid) begin
      checks++; errors++;
      $display("FAIL timeout: no out_valid within %0d cycles", lat);
    end else begin
      chk("latency", 32'(lat), 32'(e.lat));
      chk("shift_out", 32'(bus.shift_out), 32'(e.exp));
      chk("shift_flag", 32'(bus.shift_flag), 32'(e.flag));
    end
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      chk("idle_after_handshake", 32'(bus.in_ready), 32'd1);
    end
  endtask

  vec_t tbl[12];

  initial begin
    logic [W:0] m;
    vec_t v;
    int seen;

    tbl[0]  = '{16'h8001, 4'd1,  2'b01, 16'h0002, 1'b1};
    tbl[1]  = '{16'h1234, 4'd0,  2'b00, 16'h1234, 1'b0};
`ifdef ALU_ARITH_SHIFT_EN
    tbl[2]  = '{16'h0001, 4'd4,  2'b10, 16'h0000, 1'b0};
    tbl[4]  = '{16'h8000, 4'd3,  2'b10, 16'hF000, 1'b0};
    tbl[9]  = '{16'h0003, 4'd1,  2'b10, 16'h0001, 1'b1};
`else
    tbl[2]  = '{16'h0001, 4'd4,  2'b10, 16'h1000, 1'b0};
    tbl[4]  = '{16'h8000, 4'd3,  2'b10, 16'h1000, 1'b0};
    tbl[9]  = '{16'h0003, 4'd1,  2'b10, 16'h8001, 1'b1};
`endif
    tbl[3]  = '{16'h8000, 4'd1,  2'b11, 16'h0001, 1'b1};
    tbl[5]  = '{16'hFFFF, 4'd15, 2'b00, 16'h0001, 1'b1};
    tbl[6]  = '{16'h00F0, 4'd4,  2'b01, 16'h0F00, 1'b0};
    tbl[7]  = '{16'h1234, 4'd15, 2'b11, 16'h091A, 1'b0};
    tbl[8]  = '{16'h8001, 4'd1,  2'b00, 16'h4000, 1'b1};
    tbl[10] = '{16'hC000, 4'd2,  2'b11, 16'h0003, 1'b1};
    tbl[11] = '{16'hFFFF, 4'd15, 2'b01, 16'h8000, 1'b1};

    bus.in_valid = 1'b0; bus.a_in = '0; bus.amt_in = '0; bus.op_in = '0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_shift_out", 32'(bus.shift_out), 32'd0);
    chk("rst_flag", 32'(bus.shift_flag), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk); rst_shift = 1'b1;
    #1 chk("in_ready_after_rst", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < 12; i++) run_job(tbl[i], (i == 5) ? 2 : 0);

    for (int i = 0; i < 8; i++) begin
      v.a = W'($urandom); v.amt = A'($urandom); v.op = 2'($urandom);
      m = model(v.a, int'(v.amt), v.op);
      v.exp = m[W-1:0]; v.exp_flag = m[W];
      run_job(v, i % 3);
    end

    // Backpressure: result held, in_valid pulses ignored.
    v = tbl[0];
    wait_idle();
    bus.in_valid = 1'b1; bus.a_in = v.a; bus.amt_in = v.amt; bus.op_in = v.op; bus.out_ready = 1'b0;
    @(posedge clk); #1 bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("bp_valid", 32'(bus.out_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.in_valid = k[0]; bus.a_in = 16'hDEAD; bus.amt_in = 4'd7; bus.op_in = 2'b11;
      @(posedge clk); #1;
      chk("bp_hold_out", 32'(bus.shift_out), 32'h0002);
      chk("bp_hold_flag", 32'(bus.shift_flag), 32'd1);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
    end
    @(negedge clk); bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_idle", 32'(bus.in_ready), 32'd1);
    chk("bp_release_valid", 32'(bus.out_valid), 32'd0);
    chk("bp_result_visible", 32'(bus.shift_out), 32'h0002);

    // Reset in the middle of a long shift aborts the job.
    wait_idle();
    bus.in_valid = 1'b1; bus.a_in = 16'hFFFF; bus.amt_in = 4'd15; bus.op_in = 2'b01;
    @(posedge clk); #1 bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_shift = 1'b0;
    #1;
    chk("abort_shift_out", 32'(bus.shift_out), 32'd0);
    chk("abort_flag", 32'(bus.shift_flag), 32'd0);
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_shift = 1'b1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    chk("abort_no_result", 32'(seen), 32'd0);
    run_job(tbl[3], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
